// File: rtl/alu_operand_fwd.sv
// Registered ALU operand-2 select stage: register value, forwarded result or
// extended immediate. Waits a bounded time for a late forward, then falls back.
module alu_operand_fwd #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned IMM_W    = 4,
  parameter int unsigned NUM_FWD  = 2,
  parameter int unsigned SEL_W    = 2,
  parameter int unsigned WAIT_MAX = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W-1:0]         reg_val,
  input  logic [IMM_W-1:0]          imm,
  input  logic                      imm_sext,
  input  logic [SEL_W-1:0]          sel,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_data,
  input  logic [NUM_FWD-1:0]        fwd_rdy,
  output logic [DATA_W-1:0]         operand,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      stall,
  output logic [15:0]               miss_cnt
);

  localparam int unsigned CNT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t             state;
  logic [SEL_W-1:0]   lat_sel;
  logic [DATA_W-1:0]  lat_reg;
  logic [CNT_W-1:0]   wait_cnt;

  logic               accept;
  logic               sel_is_imm;
  logic [DATA_W-1:0]  imm_ext;
  logic [DATA_W-1:0]  live_data;
  logic               live_rdy;
  logic [DATA_W-1:0]  lat_data;
  logic               lat_rdy;

  assign in_ready   = (state == ST_EMPTY) || ((state == ST_FULL) && out_ready);
  assign accept     = in_valid && in_ready;
  assign sel_is_imm = (sel > SEL_W'(NUM_FWD));

  // Immediate extension: upper bits are filled with the sign bit only when requested.
  always_comb begin
    imm_ext = DATA_W'(imm);
    if (imm_sext && imm[IMM_W-1]) begin
      imm_ext = imm_ext | ~DATA_W'({IMM_W{1'b1}});
    end
  end

  // Forward source lookup for the incoming selector and for the latched one.
  always_comb begin
    live_data = '0;
    live_rdy  = 1'b0;
    lat_data  = '0;
    lat_rdy   = 1'b0;
    for (int unsigned k = 0; k < NUM_FWD; k++) begin
      if (sel == SEL_W'(k + 1)) begin
        live_data = fwd_data[k*DATA_W +: DATA_W];
        live_rdy  = fwd_rdy[k];
      end
      if (lat_sel == SEL_W'(k + 1)) begin
        lat_data = fwd_data[k*DATA_W +: DATA_W];
        lat_rdy  = fwd_rdy[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_EMPTY;
      operand   <= '0;
      out_valid <= 1'b0;
      stall     <= 1'b0;
      miss_cnt  <= '0;
      lat_sel   <= '0;
      lat_reg   <= '0;
      wait_cnt  <= '0;
    end else begin
      case (state)
        ST_EMPTY, ST_FULL: begin
          if (accept) begin
            if (sel == '0) begin
              operand   <= reg_val;
              out_valid <= 1'b1;
              state     <= ST_FULL;
            end else if (sel_is_imm) begin
              operand   <= imm_ext;
              out_valid <= 1'b1;
              state     <= ST_FULL;
            end else if (live_rdy) begin
              operand   <= live_data;
              out_valid <= 1'b1;
              state     <= ST_FULL;
            end else begin
              lat_sel   <= sel;
              lat_reg   <= reg_val;
              wait_cnt  <= '0;
              out_valid <= 1'b0;
              stall     <= 1'b1;
              state     <= ST_WAIT;
            end
          end else if ((state == ST_FULL) && out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_EMPTY;
          end
        end
        ST_WAIT: begin
          if (lat_rdy) begin
            operand   <= lat_data;
            out_valid <= 1'b1;
            stall     <= 1'b0;
            state     <= ST_FULL;
          end else if (wait_cnt == CNT_W'(WAIT_MAX - 1)) begin
            // Timeout: fall back to the register value captured at accept.
            operand   <= lat_reg;
            out_valid <= 1'b1;
            stall     <= 1'b0;
            state     <= ST_FULL;
            if (miss_cnt != 16'hFFFF) begin
              miss_cnt <= miss_cnt + 16'd1;
            end
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        default: begin
          state     <= ST_EMPTY;
          out_valid <= 1'b0;
          stall     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_operand_fwd.sv
// Self-checking bench for alu_operand_fwd: directed scenarios plus randomized
// transactions checked against a per-transaction reference model.
module tb_alu_operand_fwd;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned IMM_W    = 4;
  localparam int unsigned NUM_FWD  = 2;
  localparam int unsigned SEL_W    = 2;
  localparam int unsigned WAIT_MAX = 3;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic                      in_valid;
  logic                      in_ready;
  logic [DATA_W-1:0]         reg_val;
  logic [IMM_W-1:0]          imm;
  logic                      imm_sext;
  logic [SEL_W-1:0]          sel;
  logic [NUM_FWD*DATA_W-1:0] fwd_data;
  logic [NUM_FWD-1:0]        fwd_rdy;
  logic [DATA_W-1:0]         operand;
  logic                      out_valid;
  logic                      out_ready;
  logic                      stall;
  logic [15:0]               miss_cnt;

  int checks   = 0;
  int failures = 0;
  int exp_miss = 0;

  always #5 clk = ~clk;

  alu_operand_fwd #(
    .DATA_W(DATA_W), .IMM_W(IMM_W), .NUM_FWD(NUM_FWD), .SEL_W(SEL_W), .WAIT_MAX(WAIT_MAX)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .reg_val(reg_val), .imm(imm), .imm_sext(imm_sext), .sel(sel),
    .fwd_data(fwd_data), .fwd_rdy(fwd_rdy), .operand(operand),
    .out_valid(out_valid), .out_ready(out_ready), .stall(stall), .miss_cnt(miss_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; sel = 2'd0; reg_val = 8'h55; imm = '0; imm_sext = 1'b0;
    fwd_data = 16'hA5A5; fwd_rdy = 2'b11; out_ready = 1'b1;
    tick(); tick(); tick();
    checks++;
    if ({operand, out_valid, stall, miss_cnt} !== {8'h00, 1'b0, 1'b0, 16'h0000}) begin
      failures++;
      $display("FAIL reset_hold got op=%h v=%b st=%b miss=%h exp op=00 v=0 st=0 miss=0000",
               operand, out_valid, stall, miss_cnt);
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    checks++;
    if ({in_ready, operand, out_valid, stall} !== {1'b1, 8'h00, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_release got rdy=%b op=%h v=%b st=%b exp rdy=1 op=00 v=0 st=0",
               in_ready, operand, out_valid, stall);
    end
    tick();
  endtask

  task automatic test_imm();
    logic [7:0] exp_v [2];
    exp_v[0] = 8'h0A;
    exp_v[1] = 8'hFA;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; sel = 2'd3; imm = 4'hA; imm_sext = i[0]; fwd_rdy = 2'b00;
      tick();
      in_valid = 1'b0;
      checks++;
      if ({operand, out_valid} !== {exp_v[i], 1'b1}) begin
        failures++;
        $display("FAIL imm_ext sext=%0d got op=%h v=%b exp op=%h v=1", i, operand, out_valid, exp_v[i]);
      end
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_v [3];
    exp_v[0] = 8'h11; exp_v[1] = 8'h22; exp_v[2] = 8'h33;
    out_ready = 1'b1; reg_val = 8'h11; fwd_data = 16'h3322; fwd_rdy = 2'b11;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; sel = SEL_W'(i);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        failures++;
        $display("FAIL b2b_in_ready step=%0d got=%b exp=1", i, in_ready);
      end
      tick();
      checks++;
      if ({operand, out_valid} !== {exp_v[i], 1'b1}) begin
        failures++;
        $display("FAIL b2b_operand step=%0d got op=%h v=%b exp op=%h v=1", i, operand, out_valid, exp_v[i]);
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_late_fwd();
    out_ready = 1'b1; in_valid = 1'b1; sel = 2'd1; reg_val = 8'h99; fwd_rdy = 2'b00; fwd_data = 16'h0000;
    tick();
    in_valid = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      if (c == 2) begin
        fwd_rdy = 2'b01; fwd_data = 16'h005C;
      end
      #1;
      checks++;
      if ({stall, in_ready, out_valid} !== 3'b100) begin
        failures++;
        $display("FAIL late_wait cycle=%0d got st=%b rdy=%b v=%b exp st=1 rdy=0 v=0", c, stall, in_ready, out_valid);
      end
      tick();
    end
    fwd_rdy = 2'b00;
    checks++;
    if ({operand, out_valid, stall, miss_cnt} !== {8'h5C, 1'b1, 1'b0, 16'(exp_miss)}) begin
      failures++;
      $display("FAIL late_result got op=%h v=%b st=%b miss=%h exp op=5c v=1 st=0 miss=%h",
               operand, out_valid, stall, miss_cnt, 16'(exp_miss));
    end
    tick();
  endtask

  task automatic test_timeout();
    out_ready = 1'b1; in_valid = 1'b1; sel = 2'd2; reg_val = 8'h77; fwd_rdy = 2'b01; fwd_data = 16'hEEEE;
    tick();
    in_valid = 1'b0; reg_val = 8'h00;
    for (int c = 1; c <= int'(WAIT_MAX); c++) begin
      #1;
      checks++;
      if (stall !== 1'b1) begin
        failures++;
        $display("FAIL timeout_stall cycle=%0d got=%b exp=1", c, stall);
      end
      tick();
    end
    exp_miss++;
    checks++;
    if ({operand, out_valid, stall, miss_cnt} !== {8'h77, 1'b1, 1'b0, 16'(exp_miss)}) begin
      failures++;
      $display("FAIL timeout_result got op=%h v=%b st=%b miss=%h exp op=77 v=1 st=0 miss=%h",
               operand, out_valid, stall, miss_cnt, 16'(exp_miss));
    end
    fwd_rdy = 2'b00;
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; in_valid = 1'b1; sel = 2'd0; reg_val = 8'h44;
    tick();
    reg_val = 8'h99; sel = 2'd1; fwd_rdy = 2'b11;
    for (int c = 0; c < 3; c++) begin
      fwd_data = 16'($urandom);
      #1;
      checks++;
      if ({operand, out_valid, in_ready} !== {8'h44, 1'b1, 1'b0}) begin
        failures++;
        $display("FAIL bp_hold cycle=%0d got op=%h v=%b rdy=%b exp op=44 v=1 rdy=0", c, operand, out_valid, in_ready);
      end
      tick();
    end
    sel = 2'd0;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if ({operand, out_valid} !== {8'h99, 1'b1}) begin
      failures++;
      $display("FAIL bp_release got op=%h v=%b exp op=99 v=1", operand, out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_drain got v=%b exp v=0", out_valid);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1; in_valid = 1'b1; sel = 2'd1; reg_val = 8'h12; fwd_rdy = 2'b00;
    tick();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({operand, out_valid, stall, miss_cnt, in_ready} !== {8'h00, 1'b0, 1'b0, 16'h0000, 1'b1}) begin
      failures++;
      $display("FAIL reset_mid got op=%h v=%b st=%b miss=%h rdy=%b exp op=00 v=0 st=0 miss=0000 rdy=1",
               operand, out_valid, stall, miss_cnt, in_ready);
    end
    exp_miss = 0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Reference model: expected operand from the selection rules, wait outcome from
  // the cycle the forward arrives versus the WAIT_MAX budget.
  task automatic test_random(input int n);
    int s, idx, w, e, rv, im;
    bit sx, waiting;
    out_ready = 1'b1;
    for (int t = 0; t < n; t++) begin
      s = int'($urandom_range(0, 3)); rv = int'($urandom_range(0, 255));
      im = int'($urandom_range(0, 15)); sx = 1'($urandom);
      sel = SEL_W'(s); reg_val = DATA_W'(rv); imm = IMM_W'(im); imm_sext = sx;
      fwd_data = 16'($urandom); fwd_rdy = 2'($urandom);
      in_valid = 1'b1;
      waiting = 1'b0; idx = 0;
      if (s == 0) e = rv;
      else if (s > int'(NUM_FWD)) e = (sx && im >= 8) ? im + 240 : im;
      else begin
        idx = s - 1;
        if (fwd_rdy[idx]) e = int'(fwd_data[idx*DATA_W +: DATA_W]);
        else begin waiting = 1'b1; e = rv; end
      end
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        failures++;
        $display("FAIL rand_in_ready t=%0d got=%b exp=1", t, in_ready);
      end
      tick();
      in_valid = 1'b0;
      if (waiting) begin
        w = int'($urandom_range(1, WAIT_MAX + 1));
        for (int c = 1; c <= int'(WAIT_MAX); c++) begin
          fwd_data = 16'($urandom); fwd_rdy = 2'($urandom); fwd_rdy[idx] = (c == w);
          reg_val = DATA_W'($urandom);
          if (c == w) e = int'(fwd_data[idx*DATA_W +: DATA_W]);
          #1;
          checks++;
          if ({stall, in_ready, out_valid} !== 3'b100) begin
            failures++;
            $display("FAIL rand_wait t=%0d cycle=%0d got st=%b rdy=%b v=%b exp st=1 rdy=0 v=0",
                     t, c, stall, in_ready, out_valid);
          end
          tick();
          if (c == w) break;
        end
        if (w > int'(WAIT_MAX)) exp_miss++;
      end
      checks++;
      if ({operand, out_valid, stall, miss_cnt} !== {8'(e), 1'b1, 1'b0, 16'(exp_miss)}) begin
        failures++;
        $display("FAIL rand_result t=%0d sel=%0d got op=%h v=%b st=%b miss=%h exp op=%h v=1 st=0 miss=%h",
                 t, s, operand, out_valid, stall, miss_cnt, 8'(e), 16'(exp_miss));
      end
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_imm();
    test_back_to_back();
    test_late_fwd();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    test_random(60);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_operand_fwd.md
# alu_operand_fwd

Registered, parametrised operand-select stage that feeds ALU operand 2 in the MEX stage. It picks between the register-file value, one of NUM_FWD forwarded results, or a zero/sign-extended immediate, and latches the choice into an output register with a valid/ready handshake. When the selected forwarding source is not yet ready, it stalls the front end. A bounded wait falls back to the register value and counts the miss. It supersedes the purely combinational operand-2 multiplexer.

## Interface
- DATA_W, 8, operand width
- IMM_W, 4, immediate field width; must satisfy IMM_W <= DATA_W
- NUM_FWD, 2, number of forwarding sources (index 0 = MEX/WB ALU result, 1 = WB write-back)
- SEL_W, 2, selector width; must satisfy 2^SEL_W >= NUM_FWD+2
- WAIT_MAX, 3, maximum cycles spent in WAIT before fallback (>= 1)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid & in_ready
- reg_val  in  DATA_W  register-file operand 2
- imm  in  IMM_W  instruction immediate
- imm_sext  in  1  1 = sign-extend the immediate, 0 = zero-extend it
- sel  in  SEL_W  0 = reg_val; 1..NUM_FWD = fwd source sel-1; any value > NUM_FWD = immediate
- fwd_data  in  NUM_FWD*DATA_W  forwarded values; source k occupies bits [k*DATA_W +: DATA_W]
- fwd_rdy  in  NUM_FWD  per-source "value valid this cycle"
- operand  out  DATA_W  registered ALU operand 2
- out_valid  out  1  operand holds an unconsumed value
- out_ready  in  1  consumer takes operand when out_valid & out_ready
- stall  out  1  high while in WAIT
- miss_cnt  out  16  saturating count of WAIT timeouts

## Operation
- States: EMPTY, WAIT, FULL. Reset values:
  - state = EMPTY
  - operand = 0, out_valid = 0, stall = 0, miss_cnt = 0
  - internal latches (latched sel, latched reg_val, wait counter) = 0
- in_ready is combinational: (state==EMPTY) | (state==FULL & out_ready). It is 0 in WAIT.
- Accept from EMPTY or FULL (handshake fires):
  - sel = 0 -> operand <= reg_val; go to FULL.
  - sel > NUM_FWD -> operand <= extended imm; go to FULL.
    - Zero extension: upper DATA_W-IMM_W bits = 0.
    - Sign extension: upper bits = imm[IMM_W-1].
  - sel in 1..NUM_FWD and fwd_rdy[sel-1] = 1 -> operand <= fwd_data[sel-1]; go to FULL.
  - sel in 1..NUM_FWD and fwd_rdy[sel-1] = 0 -> latch sel and reg_val, clear the wait counter, go to WAIT. out_valid drops to 0 if the previous value was consumed this cycle.
- WAIT, each cycle:
  - fwd_rdy[latched sel-1] = 1 -> operand <= live fwd_data[latched sel-1]; go to FULL.
  - Otherwise, wait counter = WAIT_MAX-1 -> operand <= latched reg_val; miss_cnt += 1, saturating at 0xFFFF; go to FULL.
  - Otherwise, increment the wait counter.
- FULL: out_valid = 1 and operand is stable until the handshake.
  - out_ready = 1 and no new accept -> go to EMPTY, out_valid <= 0.
  - out_ready = 1 with a simultaneous accept -> the new value is loaded the same edge and out_valid stays 1.
- stall = (state == WAIT).
- Reset assertion mid-operation (any state) returns all state and outputs to reset values immediately and drops the pending request.

## Timing
- Latency for reg, immediate, or a ready forwarding source: accepted at edge t -> operand/out_valid valid after edge t (1 cycle).
- Not-ready forwarding source: if fwd_rdy is first seen high in WAIT cycle w (w = 1..WAIT_MAX), operand is valid one cycle after w.
  - Total latency ≤ WAIT_MAX+1 cycles.
  - The timeout fallback lands exactly WAIT_MAX+1 cycles after accept.
- Throughput: one operand per cycle while out_ready = 1 and no WAIT occurs.
- fwd_rdy and fwd_data are sampled only on the accept edge and in WAIT. Changes while in FULL or EMPTY have no effect.

## Test plan
- Reset: hold rst_n = 0 with in_valid = 1 -> operand = 0, out_valid = 0, stall = 0, miss_cnt = 0, in_ready = 1 after release.
- Immediate extension, DATA_W = 8, IMM_W = 4, imm = 4'hA:
  - sel = 3, imm_sext = 0 -> operand = 8'h0A after 1 cycle.
  - imm_sext = 1 -> operand = 8'hFA.
- Back-to-back: out_ready = 1; requests sel = 0 with reg_val = 8'h11, then sel = 1 with fwd0 = 8'h22 (ready), then sel = 2 with fwd1 = 8'h33 (ready) -> operand sequence 11, 22, 33 on consecutive cycles; in_ready stays 1.
- Late forward: sel = 1 with fwd_rdy[0] = 0 -> stall = 1 and in_ready = 0 for 2 cycles; fwd_rdy[0] = 1 with 8'h5C in the 2nd WAIT cycle -> operand = 8'h5C one cycle later; miss_cnt unchanged.
- Timeout: sel = 2, fwd_rdy[1] held at 0, reg_val = 8'h77, WAIT_MAX = 3 -> stall high for 3 cycles, then operand = 8'h77 and miss_cnt = 1.
- Backpressure: out_ready = 0 while FULL with operand = 8'h44 -> operand stays 8'h44, in_ready = 0, and new in_valid / fwd_data changes are ignored until out_ready = 1.
